// File: rtl/decode.sv
// LC3 decode stage: waits MEM_LAT cycles for memory data, latches IR and splits it into fields.
// Optional macro DECODE_ILLEGAL_EN flags reserved (1101) and RTI (1000) opcodes on illegal_op.
module decode #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        decode_start,
    input  logic [15:0] instr_in,
    input  logic [15:0] pc_in,
    output logic [15:0] ir_out,
    output logic [15:0] npc_out,
    output logic [3:0]  opCode_out,
    output logic [2:0]  dr_out,
    output logic [2:0]  sr1_out,
    output logic [2:0]  sr2_out,
    output logic        imm_mode,
    output logic [15:0] imm5_out,
    output logic [15:0] offset6_out,
    output logic [8:0]  offset_out,
    output logic [10:0] offset11_out,
    output logic [2:0]  br_nzp_out,
    output logic        reg_we,
    output logic        illegal_op,
    output logic        busy,
    output logic        decode_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] ir_q, ir_d;
    logic [15:0] npc_q, npc_d;
    logic        reg_we_q, reg_we_d;
    logic        new_we;
    logic        new_ill;

    // Write-enable and illegal classification of the word about to be captured.
    always_comb begin
        new_ill = 1'b0;
        unique case (instr_in[15:12])
            4'b0001, 4'b0101, 4'b1001,
            4'b0010, 4'b0110, 4'b1010, 4'b1110,
            4'b0100: new_we = 1'b1;
            default: new_we = 1'b0;
        endcase
`ifdef DECODE_ILLEGAL_EN
        new_ill = (instr_in[15:12] == 4'b1101) || (instr_in[15:12] == 4'b1000);
        if (new_ill) begin
            new_we = 1'b0;
        end
`endif
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ir_d     = ir_q;
        npc_d    = npc_q;
        reg_we_d = reg_we_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (decode_start) begin
                    npc_d   = pc_in;
                    cnt_d   = 3'(MEM_LAT - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // decode_start is deliberately not looked at here: no queueing.
                if (cnt_q == 3'd0) begin
                    ir_d     = instr_in;
                    reg_we_d = new_we;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            ir_q     <= 16'h0000;
            npc_q    <= 16'h0000;
            reg_we_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ir_q     <= ir_d;
            npc_q    <= npc_d;
            reg_we_q <= reg_we_d;
        end
    end

`ifdef DECODE_ILLEGAL_EN
    logic illegal_q, illegal_d;

    always_comb begin
        illegal_d = illegal_q;
        if (state_q == S_WAIT && cnt_q == 3'd0) begin
            illegal_d = new_ill;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end

    assign illegal_op = illegal_q;
`else
    logic unused_ill;
    assign unused_ill = new_ill;
    assign illegal_op = 1'b0;
`endif

    // Field outputs are pure slices of the IR flop, so they never see instr_in directly.
    assign ir_out       = ir_q;
    assign npc_out      = npc_q;
    assign opCode_out   = ir_q[15:12];
    assign dr_out       = (ir_q[15:12] == 4'b0100) ? 3'b111 : ir_q[11:9];
    assign sr1_out      = ir_q[8:6];
    assign sr2_out      = ir_q[2:0];
    assign imm_mode     = ir_q[5];
    assign imm5_out     = {{11{ir_q[4]}}, ir_q[4:0]};
    assign offset6_out  = {{10{ir_q[5]}}, ir_q[5:0]};
    assign offset_out   = ir_q[8:0];
    assign offset11_out = ir_q[10:0];
    assign br_nzp_out   = ir_q[11:9];
    assign reg_we       = reg_we_q;
    assign busy         = (state_q != S_IDLE);
    assign decode_done  = (state_q == S_DONE);

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for decode: two instances (MEM_LAT=1 and MEM_LAT=3) driven with directed words.
// Expected illegal_op follows DECODE_ILLEGAL_EN.
module tb_decode;

    typedef struct {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [3:0]  opc;
        logic [2:0]  dr;
        logic [2:0]  sr1;
        logic [2:0]  sr2;
        logic [2:0]  nzp;
        logic        imm;
        logic [15:0] imm5;
        logic [15:0] off6;
        logic [8:0]  off9;
        logic [10:0] off11;
        logic        we;
        logic        ill;
        int          cyc;
    } exp_t;

`ifdef DECODE_ILLEGAL_EN
    localparam logic ILL = 1'b1;
`else
    localparam logic ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start [2];
    logic [15:0] instr [2];
    logic [15:0] pc    [2];
    logic [15:0] ir_o [2], npc_o [2], imm5_o [2], off6_o [2];
    logic [3:0]  opc_o [2];
    logic [2:0]  dr_o [2], sr1_o [2], sr2_o [2], nzp_o [2];
    logic        imm_o [2], we_o [2], ill_o [2], busy_o [2], done_o [2];
    logic [8:0]  off9_o [2];
    logic [10:0] off11_o [2];

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    exp_t sb0 [$];
    exp_t sb1 [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    decode #(.MEM_LAT(1)) u_lat1 (
        .clk(clk), .rst_n(rst_n), .decode_start(start[0]), .instr_in(instr[0]), .pc_in(pc[0]),
        .ir_out(ir_o[0]), .npc_out(npc_o[0]), .opCode_out(opc_o[0]), .dr_out(dr_o[0]),
        .sr1_out(sr1_o[0]), .sr2_out(sr2_o[0]), .imm_mode(imm_o[0]), .imm5_out(imm5_o[0]),
        .offset6_out(off6_o[0]), .offset_out(off9_o[0]), .offset11_out(off11_o[0]),
        .br_nzp_out(nzp_o[0]), .reg_we(we_o[0]), .illegal_op(ill_o[0]), .busy(busy_o[0]),
        .decode_done(done_o[0])
    );

    decode #(.MEM_LAT(3)) u_lat3 (
        .clk(clk), .rst_n(rst_n), .decode_start(start[1]), .instr_in(instr[1]), .pc_in(pc[1]),
        .ir_out(ir_o[1]), .npc_out(npc_o[1]), .opCode_out(opc_o[1]), .dr_out(dr_o[1]),
        .sr1_out(sr1_o[1]), .sr2_out(sr2_o[1]), .imm_mode(imm_o[1]), .imm5_out(imm5_o[1]),
        .offset6_out(off6_o[1]), .offset_out(off9_o[1]), .offset11_out(off11_o[1]),
        .br_nzp_out(nzp_o[1]), .reg_we(we_o[1]), .illegal_op(ill_o[1]), .busy(busy_o[1]),
        .decode_done(done_o[1])
    );

    function automatic exp_t mk(input logic [15:0] ir, input logic [15:0] npc, input logic [3:0] opc,
                                input logic [2:0] dr, input logic [2:0] sr1, input logic [2:0] sr2,
                                input logic [2:0] nzp, input logic imm, input logic [15:0] imm5,
                                input logic [15:0] off6, input logic [8:0] off9,
                                input logic [10:0] off11, input logic we, input logic ill);
        exp_t e;
        e.ir = ir; e.npc = npc; e.opc = opc; e.dr = dr; e.sr1 = sr1; e.sr2 = sr2; e.nzp = nzp;
        e.imm = imm; e.imm5 = imm5; e.off6 = off6; e.off9 = off9; e.off11 = off11;
        e.we = we; e.ill = ill; e.cyc = 0;
        return e;
    endfunction

    function automatic exp_t sample(input int k);
        exp_t a;
        a.ir = ir_o[k]; a.npc = npc_o[k]; a.opc = opc_o[k]; a.dr = dr_o[k]; a.sr1 = sr1_o[k];
        a.sr2 = sr2_o[k]; a.nzp = nzp_o[k]; a.imm = imm_o[k]; a.imm5 = imm5_o[k];
        a.off6 = off6_o[k]; a.off9 = off9_o[k]; a.off11 = off11_o[k]; a.we = we_o[k];
        a.ill = ill_o[k]; a.cyc = cyc;
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic compareAll(input string tag, input exp_t a, input exp_t e);
        checkOutput({tag, ".ir"}, 32'(a.ir), 32'(e.ir));
        checkOutput({tag, ".npc"}, 32'(a.npc), 32'(e.npc));
        checkOutput({tag, ".opcode"}, 32'(a.opc), 32'(e.opc));
        checkOutput({tag, ".dr"}, 32'(a.dr), 32'(e.dr));
        checkOutput({tag, ".sr1"}, 32'(a.sr1), 32'(e.sr1));
        checkOutput({tag, ".sr2"}, 32'(a.sr2), 32'(e.sr2));
        checkOutput({tag, ".nzp"}, 32'(a.nzp), 32'(e.nzp));
        checkOutput({tag, ".imm_mode"}, 32'(a.imm), 32'(e.imm));
        checkOutput({tag, ".imm5"}, 32'(a.imm5), 32'(e.imm5));
        checkOutput({tag, ".offset6"}, 32'(a.off6), 32'(e.off6));
        checkOutput({tag, ".offset9"}, 32'(a.off9), 32'(e.off9));
        checkOutput({tag, ".offset11"}, 32'(a.off11), 32'(e.off11));
        checkOutput({tag, ".reg_we"}, 32'(a.we), 32'(e.we));
        checkOutput({tag, ".illegal"}, 32'(a.ill), 32'(e.ill));
        checkOutput({tag, ".done_cycle"}, 32'(a.cyc), 32'(e.cyc));
    endtask

    task automatic checkZero(input int k, input string tag);
        exp_t z;
        z = mk(16'h0, 16'h0, 4'h0, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 16'h0, 9'h0, 11'h0, 1'b0, 1'b0);
        z.cyc = cyc;
        compareAll(tag, sample(k), z);
        checkOutput({tag, ".busy"}, 32'(busy_o[k]), 32'd0);
        checkOutput({tag, ".done"}, 32'(done_o[k]), 32'd0);
    endtask

    // Drives one request at a negedge and queues its expected response; start drops a cycle later.
    task automatic applyStimulus(input int k, input logic [15:0] w, input logic [15:0] p,
                                 input exp_t e, input int lat);
        @(negedge clk);
        start[k] = 1'b1;
        instr[k] = w;
        pc[k]    = p;
        e.cyc    = cyc + 1 + lat;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(negedge clk);
        start[k] = 1'b0;
        pc[k]    = 16'hDEAD;
    endtask

    // Monitor: every decode_done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (done_o[k] === 1'b1) begin
                if ((k == 0 ? sb0.size() : sb1.size()) == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL dut%0d.unexpected_done: got done=1 expected no pulse at cycle %0d", k, cyc);
                end else if (k == 0) begin
                    compareAll("dut0", sample(0), sb0.pop_front());
                end else begin
                    compareAll("dut1", sample(1), sb1.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0;
            instr[k] = 16'h0000;
            pc[k]    = 16'h0000;
        end
        repeat (5) @(negedge clk);
        checkZero(0, "rst0");
        checkZero(1, "rst1");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkZero(0, "idle0");
        checkZero(1, "idle1");

        // MEM_LAT=1 instance: BRnp, ADD immediate, ST (no write).
        applyStimulus(0, 16'h0BFE, 16'h3001, mk(16'h0BFE, 16'h3001, 4'h0, 3'd5, 3'd7, 3'd6, 3'd5, 1'b1,
                      16'hFFFE, 16'hFFFE, 9'h1FE, 11'h3FE, 1'b0, 1'b0), 1);
        repeat (3) @(negedge clk);
        applyStimulus(0, 16'h12BD, 16'h3002, mk(16'h12BD, 16'h3002, 4'h1, 3'd1, 3'd2, 3'd5, 3'd1, 1'b1,
                      16'hFFFD, 16'hFFFD, 9'h0BD, 11'h2BD, 1'b1, 1'b0), 1);
        repeat (3) @(negedge clk);
        applyStimulus(0, 16'h3000, 16'h3003, mk(16'h3000, 16'h3003, 4'h3, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0,
                      16'h0000, 16'h0000, 9'h000, 11'h000, 1'b0, 1'b0), 1);
        repeat (3) @(negedge clk);

        // MEM_LAT=3: JSR, start held through WAIT (ignored), then LDR accepted back-to-back from DONE.
        @(negedge clk);
        start[1] = 1'b1;
        instr[1] = 16'h4805;
        pc[1]    = 16'h3100;
        begin
            exp_t e;
            e = mk(16'h4805, 16'h3100, 4'h4, 3'd7, 3'd0, 3'd5, 3'd4, 1'b0,
                   16'h0005, 16'h0005, 9'h005, 11'h005, 1'b1, 1'b0);
            e.cyc = cyc + 4;
            sb1.push_back(e);
        end
        @(negedge clk);
        pc[1] = 16'hBEEF;
        checkOutput("dut1.busy_wait", 32'(busy_o[1]), 32'd1);
        for (int i = 0; i < 10 && done_o[1] !== 1'b1; i++) @(negedge clk);
        checkOutput("dut1.jsr_done_seen", 32'(done_o[1]), 32'd1);
        instr[1] = 16'h673F;
        pc[1]    = 16'h4000;
        begin
            exp_t e;
            e = mk(16'h673F, 16'h4000, 4'h6, 3'd3, 3'd4, 3'd7, 3'd3, 1'b1,
                   16'hFFFF, 16'hFFFF, 9'h13F, 11'h73F, 1'b1, 1'b0);
            e.cyc = cyc + 4;
            sb1.push_back(e);
        end
        @(negedge clk);
        start[1] = 1'b0;
        pc[1]    = 16'hDEAD;
        repeat (6) @(negedge clk);

        // Reset in the middle of WAIT drops the pending decode.
        @(negedge clk);
        start[1] = 1'b1;
        instr[1] = 16'h12BD;
        pc[1]    = 16'h5555;
        @(negedge clk);
        start[1] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkZero(1, "midwait_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checkOutput("dut1.busy_after_rst", 32'(busy_o[1]), 32'd0);

        applyStimulus(1, 16'h9A7F, 16'h6000, mk(16'h9A7F, 16'h6000, 4'h9, 3'd5, 3'd1, 3'd7, 3'd5, 1'b1,
                      16'hFFFF, 16'hFFFF, 9'h07F, 11'h27F, 1'b1, 1'b0), 3);
        repeat (5) @(negedge clk);
        applyStimulus(1, 16'hC1C0, 16'h6001, mk(16'hC1C0, 16'h6001, 4'hC, 3'd0, 3'd7, 3'd0, 3'd0, 1'b0,
                      16'h0000, 16'h0000, 9'h1C0, 11'h1C0, 1'b0, 1'b0), 3);
        repeat (5) @(negedge clk);

        // Reserved opcode followed by AND.
        applyStimulus(0, 16'hD000, 16'h7000, mk(16'hD000, 16'h7000, 4'hD, 3'd0, 3'd0, 3'd0, 3'd0, 1'b0,
                      16'h0000, 16'h0000, 9'h000, 11'h000, 1'b0, ILL), 1);
        repeat (3) @(negedge clk);
        applyStimulus(0, 16'h5020, 16'h7001, mk(16'h5020, 16'h7001, 4'h5, 3'd0, 3'd0, 3'd0, 3'd0, 1'b1,
                      16'h0000, 16'hFFE0, 9'h020, 11'h020, 1'b1, 1'b0), 1);
        repeat (4) @(negedge clk);

        checkOutput("dut0.pending_left", 32'(sb0.size()), 32'd0);
        checkOutput("dut1.pending_left", 32'(sb1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- LC3 decode stage, directly downstream of `fetch`.
- Memory returns the instruction word at `fetch`'s `addr_out`; this block waits the memory read latency, latches the word into IR, and splits it into fields.
- Fields fan out to the register file, the ALU and back to `fetch` (`opCode_in`, `offset_in`, `br_nzp`, `reg_in` source select).
- Single-cycle `decode_done` pulse tells the controller when outputs are valid.

Parameters:
- MEM_LAT, 1, memory read latency in cycles between `decode_start` acceptance and IR capture; legal range 1..7.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- decode_start  input  1  request to decode the word being read at the current PC.
- instr_in  input  16  memory read data.
- pc_in  input  16  PC from `fetch`, sampled with `decode_start`.
- ir_out  output  16  latched instruction register.
- npc_out  output  16  PC captured at `decode_start` acceptance.
- opCode_out  output  4  IR[15:12].
- dr_out  output  3  IR[11:9]; forced 3'b111 for opcode 0100 (JSR/JSRR).
- sr1_out  output  3  IR[8:6].
- sr2_out  output  3  IR[2:0].
- imm_mode  output  1  IR[5], valid for ADD/AND.
- imm5_out  output  16  IR[4:0] sign-extended to 16 bits.
- offset6_out  output  16  IR[5:0] sign-extended.
- offset_out  output  9  IR[8:0], raw, feeds `fetch` `offset_in`.
- offset11_out  output  11  IR[10:0], raw.
- br_nzp_out  output  3  IR[11:9], feeds `fetch` `br_nzp`.
- reg_we  output  1  destination register write required.
- illegal_op  output  1  reserved/unsupported opcode flag.
- busy  output  1  high while state is not IDLE.
- decode_done  output  1  one-cycle pulse; all decoded outputs valid from this cycle on.

Behaviour:
- Reset:
  - Asynchronous, active-low: state to IDLE, wait counter 0.
  - Every output to 0, including `ir_out`, `npc_out`, `decode_done` and `busy`.
  - A reset mid-WAIT drops the pending decode; no `decode_done` follows.
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - `decode_start`=1 at edge T0: capture `pc_in` into `npc_out`, load counter with MEM_LAT-1, go to WAIT.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0 (edge T0+MEM_LAT), capture `instr_in` into IR, register all decoded fields, set `decode_done`=1, go to DONE.
- DONE (one cycle, `decode_done`=1):
  - `decode_start`=1: behave as IDLE acceptance (back-to-back decodes, one per MEM_LAT+1 cycles).
  - Otherwise return to IDLE.
  - `decode_done` clears on the next edge.
- `decode_start` in WAIT is ignored (no queueing).
- Decoded outputs hold their values until the next IR capture or reset.
- All field outputs are registered from the captured IR; no combinational path from `instr_in` to outputs.
- `reg_we`=1 for these opcodes, else 0:
  - 0001 ADD, 0101 AND, 1001 NOT
  - 0010 LD, 0110 LDR, 1010 LDI, 1110 LEA
  - 0100 JSR/JSRR
- Sign extension: replicate bit 4 for `imm5_out` and bit 5 for `offset6_out` into the upper bits.
- BR with IR[11:9]=000 decodes normally (`br_nzp_out`=000); `fetch` treats it as never-taken.

Optional Feature:
- Macro `DECODE_ILLEGAL_EN`.
- Defined:
  - `illegal_op`=1 when opcode is 1101 (reserved) or 1000 (RTI, unsupported).
  - In that case `reg_we` is forced 0.
  - `illegal_op` updates at IR capture alongside the other fields.
- Undefined:
  - `illegal_op` is tied 0.
  - These opcodes decode fields normally with `reg_we`=0.

Test Plan:
- Reset held 5 cycles, then released with `decode_start`=0 -> every output 0, `busy`=0, no `decode_done`.
- MEM_LAT=1, `pc_in`=0x3001, `instr_in`=0x0BFE (BRnp) -> `decode_done` pulses exactly 1 cycle after acceptance; outputs:
  - `opCode_out`=0000, `br_nzp_out`=101, `offset_out`=0x1FE
  - `npc_out`=0x3001, `reg_we`=0
- `instr_in`=0x12BD (ADD R1,R2,#-3) -> outputs:
  - `dr_out`=1, `sr1_out`=2, `imm_mode`=1
  - `imm5_out`=0xFFFD, `reg_we`=1
- MEM_LAT=3; `instr_in`=0x4805 (JSR) then back-to-back `decode_start` in DONE with 0x673F (LDR R3,R4,#-1):
  - JSR: `dr_out`=7, `offset11_out`=0x005, `reg_we`=1, `decode_done` 3 cycles after acceptance.
  - LDR: `decode_done` 4 cycles after the JSR pulse; `dr_out`=3, `sr1_out`=4, `offset6_out`=0xFFFF.
- `rst_n` asserted during WAIT -> outputs 0 immediately; after release no `decode_done`; a new `decode_start` is accepted normally.
- With `DECODE_ILLEGAL_EN`, `instr_in`=0xD000 -> `illegal_op`=1, `reg_we`=0; following 0x5020 (AND) -> `illegal_op`=0, `reg_we`=1. Without the macro -> `illegal_op` stays 0.
